spart_bus_ctrl: RTL and testbench

//  Sequences the SPART processor bus for the rest of the design.
//  - After reset, programs the baud divisor from br_cfg into DB low then DB high.
//  - Then arbitrates one bus access at a time between a 4-entry TX byte FIFO and a 1-entry RX holding register.
//  - Sits between the host logic and the SPART.
//  - Is the only block that drives iocs, iorw and ioaddr.

---
 rtl/spart_bus_ctrl.sv | 97 +++++++++
 tb/tb_spart_bus_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/spart_bus_ctrl.sv
// spart_bus_ctrl: programs the SPART baud divisor, then arbitrates single bus
// accesses between a small TX byte FIFO and a one-entry RX holding register.
module spart_bus_ctrl #(
  parameter int          TX_DEPTH = 4,
  parameter logic [15:0] DIV0     = 16'd5208,
  parameter logic [15:0] DIV1     = 16'd2604,
  parameter logic [15:0] DIV2     = 16'd1302,
  parameter logic [15:0] DIV3     = 16'd651
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] br_cfg_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       cfg_done_o,
  output logic       iocs_o,
  output logic       iorw_o,
  output logic [1:0] ioaddr_o,
  input  logic       rda_i,
  input  logic       tbr_i,
  inout  wire  [7:0] databus_io
);
  localparam int AW = $clog2(TX_DEPTH);
  localparam logic [2:0] CFG_LO = 3'd0, CFG_HI = 3'd1, IDLE = 3'd2,
                         RX_RD = 3'd3, TX_WR = 3'd4, RECOV = 3'd5;
  logic [2:0]  state_q, state_d;
  logic [1:0]  cfg_q, cfg_d, cfg_sel;
  logic        boot_q, cfg_done_q, cfg_done_d;
  logic [AW:0] wp_q, rp_q;
  logic [7:0]  mem_q [TX_DEPTH];
  logic [7:0]  rx_data_q, dout;
  logic        rx_valid_q;
  logic        empty, full, push, pop, cap, cfg_chg, bus;
  logic [15:0] div;
  assign empty   = wp_q == rp_q;
  assign full    = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign push    = tx_valid_i & ~full;
  assign pop     = state_q == TX_WR;
  assign cap     = state_q == RX_RD;
  assign cfg_chg = br_cfg_i != cfg_q;
  // The first CFG_LO after reset release takes br_cfg directly and latches it.
  assign cfg_sel = boot_q ? br_cfg_i : cfg_q;
  assign div     = cfg_sel == 2'd0 ? DIV0 : cfg_sel == 2'd1 ? DIV1 :
                   cfg_sel == 2'd2 ? DIV2 : DIV3;
  always_comb begin
    state_d    = state_q == CFG_LO ? CFG_HI :
                 state_q == IDLE   ? (cfg_chg ? CFG_LO :
                                      (rda_i & ~rx_valid_q) ? RX_RD :
                                      (tbr_i & ~empty) ? TX_WR : IDLE) :
                 state_q == RECOV  ? IDLE :
                 (state_q == CFG_HI || cap || pop) ? RECOV : CFG_LO;
    cfg_d      = (boot_q || (state_q == IDLE && cfg_chg)) ? br_cfg_i : cfg_q;
    cfg_done_d = state_q == CFG_HI ? 1'b1 :
                 (state_q == IDLE && cfg_chg) ? 1'b0 : cfg_done_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= CFG_LO;
      cfg_q      <= 2'd0;
      boot_q     <= 1'b1;
      cfg_done_q <= 1'b0;
      wp_q       <= '0;
      rp_q       <= '0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      cfg_q      <= cfg_d;
      boot_q     <= 1'b0;
      cfg_done_q <= cfg_done_d;
      wp_q       <= wp_q + {{AW{1'b0}}, push};
      rp_q       <= rp_q + {{AW{1'b0}}, pop};
      rx_valid_q <= cap | (rx_valid_q & ~rx_ready_i);
      if (cap) rx_data_q <= databus_io;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q[AW-1:0]] <= tx_data_i;
  end
  // Bus strobes decode from state but are forced off while reset is held.
  assign bus        = ~rst & (state_q == CFG_LO || state_q == CFG_HI || cap || pop);
  assign iocs_o     = bus;
  assign iorw_o     = ~bus | cap;
  assign ioaddr_o   = ~bus ? 2'b00 : state_q == CFG_LO ? 2'b10 :
                      state_q == CFG_HI ? 2'b11 : 2'b00;
  assign dout       = state_q == CFG_LO ? div[7:0] :
                      state_q == CFG_HI ? div[15:8] : mem_q[rp_q[AW-1:0]];
  assign databus_io = (iocs_o & ~iorw_o) ? dout : 8'hzz;
  assign tx_ready_o = ~full;
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign cfg_done_o = cfg_done_q;
endmodule

// File: tb/tb_spart_bus_ctrl.sv
// tb_spart_bus_ctrl: scoreboarded bus monitor plus table-driven divisor checks
// and directed sequences for arbitration, FIFO fill and reset corner cases.
module tb_spart_bus_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] br_cfg = 2'b01;
  logic [7:0] tx_data = 8'd0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic       cfg_done;
  logic       iocs, iorw;
  logic [1:0] ioaddr;
  logic       rda = 1'b0;
  logic       tbr = 1'b0;
  logic [7:0] sp_byte = 8'd0;
  wire  [7:0] databus;
  typedef struct {
    logic [1:0] cfg;
    logic [7:0] lo;
    logic [7:0] hi;
  } cfg_vec_t;
  cfg_vec_t    tbl [4];
  logic [10:0] exp_q [$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        prev_cs = 1'b0;
  logic [1:0]  prev_addr = 2'b00;
  always #5 clk = ~clk;
  assign databus = (iocs && iorw) ? sp_byte : 8'hzz;
  spart_bus_ctrl dut (
    .clk(clk), .rst(rst), .br_cfg_i(br_cfg),
    .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
    .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_ready_i(rx_ready),
    .cfg_done_o(cfg_done), .iocs_o(iocs), .iorw_o(iorw), .ioaddr_o(ioaddr),
    .rda_i(rda), .tbr_i(tbr), .databus_io(databus)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic expw(input logic [1:0] a, input logic [7:0] d);
    exp_q.push_back({1'b0, a, d});
  endtask
  task automatic expr(input logic [7:0] d);
    exp_q.push_back({1'b1, 2'b00, d});
  endtask
  task automatic drain(input string name, input int max);
    int n = 0;
    while (exp_q.size() != 0 && n < max) begin
      tick(1);
      n++;
    end
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask
  task automatic wait_txwr(input string name);
    logic seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (iocs && !iorw && ioaddr == 2'b00) seen = 1'b1;
      else tick(1);
    end
    check(name, seen, 1'b1);
  endtask
  always @(negedge clk) begin
    logic [10:0] e;
    if (iocs) begin
      if (prev_cs) check("recov gap", {prev_addr, ioaddr}, 4'b1011);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected access: got rw=%b addr=%b data=%h want none", iorw, ioaddr, databus);
      end else begin
        e = exp_q.pop_front();
        check("bus access", {iorw, ioaddr, databus}, e);
      end
    end
    prev_cs   = iocs;
    prev_addr = ioaddr;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [7:0] vals [5];
    tbl[0] = '{2'b00, 8'h58, 8'h14};
    tbl[1] = '{2'b10, 8'h16, 8'h05};
    tbl[2] = '{2'b01, 8'h2C, 8'h0A};
    tbl[3] = '{2'b11, 8'h8B, 8'h02};
    vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    tick(2);
    check("rst iocs", iocs, 1'b0);
    check("rst iorw", iorw, 1'b1);
    check("rst ioaddr", ioaddr, 2'b00);
    check("rst tx_ready", tx_ready, 1'b1);
    check("rst rx_valid", rx_valid, 1'b0);
    check("rst rx_data", rx_data, 8'h00);
    check("rst cfg_done", cfg_done, 1'b0);
    expw(2'b10, 8'h2C);
    expw(2'b11, 8'h0A);
    rst = 1'b0;
    tick(1);
    check("cfg_done after 1", cfg_done, 1'b0);
    tick(1);
    check("cfg_done after 2", cfg_done, 1'b1);
    check("boot writes", exp_q.size(), 0);
    tick(2);
    tbr = 1'b1;
    tx_data = 8'h6D;
    tx_valid = 1'b1;
    expw(2'b00, 8'h6D);
    tick(1);
    tx_valid = 1'b0;
    drain("single tx", 10);
    check("tx_ready after tx", tx_ready, 1'b1);
    tick(2);
    sp_byte = 8'hA5;
    rda = 1'b1;
    expr(8'hA5);
    tick(1);
    check("rx_valid latency 1", rx_valid, 1'b0);
    tick(1);
    check("rx_valid latency 2", rx_valid, 1'b1);
    check("rx_data read", rx_data, 8'hA5);
    tick(6);
    check("rx held", rx_valid, 1'b1);
    rx_ready = 1'b1;
    rda = 1'b0;
    tick(1);
    rx_ready = 1'b0;
    check("rx popped", rx_valid, 1'b0);
    tick(2);
    tbr = 1'b0;
    tx_data = 8'h3C;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    sp_byte = 8'h5A;
    rda = 1'b1;
    tbr = 1'b1;
    expr(8'h5A);
    expw(2'b00, 8'h3C);
    drain("rx before tx", 20);
    rda = 1'b0;
    check("prio rx_data", rx_data, 8'h5A);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    tick(2);
    tbr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tx_data = vals[i];
      tx_valid = 1'b1;
      if (i < 4) expw(2'b00, vals[i]);
      tick(1);
      check($sformatf("tx_ready push %0d", i), tx_ready, (i >= 3) ? 1'b0 : 1'b1);
    end
    tx_valid = 1'b0;
    tbr = 1'b1;
    drain("fifo burst", 40);
    tick(3);
    check("tx_ready drained", tx_ready, 1'b1);
    tbr = 1'b0;
    tx_data = 8'h77;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    expw(2'b00, 8'h77);
    expw(2'b10, 8'h8B);
    expw(2'b11, 8'h02);
    tbr = 1'b1;
    wait_txwr("txwr before cfg change");
    br_cfg = 2'b11;
    tick(3);
    check("cfg_done cleared", cfg_done, 1'b0);
    drain("tx then reconfig", 20);
    check("cfg_done reconfig", cfg_done, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick(2);
      br_cfg = tbl[i].cfg;
      expw(2'b10, tbl[i].lo);
      expw(2'b11, tbl[i].hi);
      tick(1);
      check($sformatf("tbl%0d cfg_done low", i), cfg_done, 1'b0);
      drain($sformatf("tbl%0d writes", i), 20);
      check($sformatf("tbl%0d cfg_done high", i), cfg_done, 1'b1);
    end
    tick(2);
    tbr = 1'b0;
    tx_valid = 1'b1;
    tx_data = 8'hAA;
    tick(1);
    tx_data = 8'hBB;
    tick(1);
    tx_valid = 1'b0;
    tbr = 1'b1;
    wait_txwr("txwr before reset");
    rst = 1'b1;
    #1;
    check("mid rst iocs", iocs, 1'b0);
    check("mid rst iorw", iorw, 1'b1);
    check("mid rst cfg_done", cfg_done, 1'b0);
    check("mid rst tx_ready", tx_ready, 1'b1);
    tick(2);
    expw(2'b10, 8'h8B);
    expw(2'b11, 8'h02);
    rst = 1'b0;
    drain("reconfig after rst", 20);
    tick(6);
    check("cfg_done after rst", cfg_done, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
